dm_lsu: RTL
===========

# dm_lsu

Load/store unit for the MEM stage: the initiator that drives the word-only data memory port (DMWr, DMRe, addr, din, dout). It accepts one pipeline request at a time and performs loads and stores of words, halfwords and bytes. Loads are sign- or zero-extended. Sub-word stores use read-modify-write, because the memory writes whole words only. Misaligned accesses are rejected with an error response.

## Interface
- ALIGN_CHECK, 1, 1: misaligned half/word requests return rsp_err; 0: the low address bits below the access size are ignored.
- clk  in  1  rising-edge clock, shared with the data memory.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE with rst low.
- req_we  in  1  1 = store, 0 = load.
- req_type  in  3  width/sign code: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned; other codes are invalid.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the sub-word is in the low bits.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid; misaligned access or invalid type.
- DMWr  out  1  memory write enable.
- DMRe  out  1  memory read enable.
- addr  out  32  word address {lat_addr[31:2], 2'b00}.
- din  out  32  memory write word.
- dout  in  32  memory read word; combinational while DMRe is high.

## Operation
- States: IDLE, READ, RMW_RD, WRITE, RESP.
- Accept: req_valid & req_ready at a rising edge. On accept, latch we, type, addr and wdata.
- Checks are made at accept. A request is in error if:
  - ALIGN_CHECK=1 and a half access has addr[0]=1;
  - ALIGN_CHECK=1 and a word access has addr[1:0]≠0;
  - the type code is invalid.
- An error goes IDLE→RESP with rsp_err=1 and causes no memory access.
- Next state from IDLE on a good request:
  - load → READ;
  - word store → WRITE;
  - half or byte store → RMW_RD.
- READ:
  - DMRe=1.
  - At the edge, select the lane from dout and extend it into rsp_rdata. Byte k = dout[8k+7:8k], k=addr[1:0]. Half = dout[16h+15:16h], h=addr[1].
  - Signed types sign-extend; unsigned types zero-extend.
  - Next state: RESP.
- RMW_RD:
  - DMRe=1.
  - At the edge, latch merge = dout with only the target lane replaced by wdata[7:0] or wdata[15:0].
  - Next state: WRITE.
- WRITE:
  - DMWr=1.
  - din = wdata for a word store; din = merge for a sub-word store.
  - Next state: RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Outside READ/RMW_RD/WRITE: DMWr=0, DMRe=0, addr=0, din=0.
- Memory-side outputs and req_ready are gated with ~rst combinationally, so no write commits during a reset cycle.
- rsp_rdata and rsp_err hold their values until the next RESP.

## Timing
- Accept at edge 0.
- Load: READ in cycle 1; rsp_valid in cycle 2. Latency 2, throughput one load per 3 cycles.
- Word store: WRITE in cycle 1, memory updated at edge 2; rsp_valid in cycle 2.
- Sub-word store: RMW_RD in cycle 1, WRITE in cycle 2, memory updated at edge 3; rsp_valid in cycle 3.
- Error: rsp_valid and rsp_err in cycle 1.
- req_ready is low from the cycle after accept until IDLE is re-entered, i.e. the cycle after RESP. The pipeline stalls on ~req_ready.
- Reset values: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, DMWr=0, DMRe=0, addr=0, din=0, req_ready=0 while rst is high.
- rst in any state aborts the operation at that edge with no response. A sub-word store aborted in RMW_RD leaves memory unchanged. rst during WRITE suppresses DMWr that cycle.
- req_valid while req_ready=0 is ignored; the requester must hold it.

## Test plan
- Word store then load:
  - stimulus: store 0xDEADBEEF @0x10, then load word @0x10;
  - response: DMWr pulse with addr=0x10, din=0xDEADBEEF; load rsp_rdata=0xDEADBEEF at accept+2.
- Byte RMW:
  - stimulus: mem[0x20]=0x11223344; store byte 0xAA @0x21;
  - response: DMRe cycle, then DMWr with din=0x1122AA44; rsp_valid at accept+3.
- Extension:
  - stimulus: mem[0x30]=0x8001FF7F; load half @0x32, half unsigned @0x32, byte @0x30, byte unsigned @0x31;
  - response: 0xFFFF8001, 0x00008001, 0x0000007F, 0x000000FF respectively.
- Errors:
  - stimulus: word load @0x13, half store @0x31, type 3'b111;
  - response: each gives rsp_err=1 and rsp_valid at accept+1, with DMWr and DMRe never asserted.
- Reset mid-RMW:
  - stimulus: assert rst in RMW_RD of a byte store;
  - response: no DMWr, memory unchanged, no rsp_valid; req_ready=1 the cycle after rst drops.
- Back-to-back requests:
  - stimulus: hold req_valid for 3 loads;
  - response: accepts spaced 3 cycles apart; each rsp_valid is a single-cycle pulse.

Source files
------------

// File: rtl/dm_lsu.sv
// Load/store unit driving a word-only data memory port.
// Sub-word stores are done as read-modify-write.
module dm_lsu #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        DMWr,
    output logic        DMRe,
    output logic [31:0] addr,
    output logic [31:0] din,
    input  logic [31:0] dout
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RMW_RD,
        WRITE,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic        lat_we;
    logic [2:0]  lat_type;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] merge_q;

    logic        accept;
    logic        req_word, req_half, req_err;
    logic        lat_word, lat_half;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;
    logic [31:0] merge_d;

    // Request classification is done on the live request, at accept time.
    always_comb begin
        req_word = (req_type == 3'd0);
        req_half = (req_type == 3'd1) || (req_type == 3'd2);
        req_err  = (req_type > 3'd4);
        if (ALIGN_CHECK) begin
            if (req_half && req_addr[0])
                req_err = 1'b1;
            if (req_word && (req_addr[1:0] != 2'b00))
                req_err = 1'b1;
        end
    end

    assign accept = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_d = RESP;
                    else if (!req_we)
                        state_d = READ;
                    else if (req_word)
                        state_d = WRITE;
                    else
                        state_d = RMW_RD;
                end
            end
            READ:    state_d = RESP;
            RMW_RD:  state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane extraction and merge, both working on the latched request.
    always_comb begin
        lat_word = (lat_type == 3'd0);
        lat_half = (lat_type == 3'd1) || (lat_type == 3'd2);
        lane_h   = lat_addr[1] ? dout[31:16] : dout[15:0];
        case (lat_addr[1:0])
            2'd0:    lane_b = dout[7:0];
            2'd1:    lane_b = dout[15:8];
            2'd2:    lane_b = dout[23:16];
            default: lane_b = dout[31:24];
        endcase
        case (lat_type)
            3'd0:    load_ext = dout;
            3'd1:    load_ext = {{16{lane_h[15]}}, lane_h};
            3'd2:    load_ext = {16'h0000, lane_h};
            3'd3:    load_ext = {{24{lane_b[7]}}, lane_b};
            default: load_ext = {24'h000000, lane_b};
        endcase
        merge_d = dout;
        if (lat_half)
            merge_d[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
        else
            merge_d[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_type  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            merge_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                lat_we    <= req_we;
                lat_type  <= req_type;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                if (req_err) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end
            end
            case (state_q)
                READ: begin
                    rsp_rdata <= load_ext;
                    rsp_err   <= 1'b0;
                end
                RMW_RD: merge_q <= merge_d;
                WRITE: begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Everything facing the pipeline or the memory is forced quiet during reset.
    always_comb begin
        req_ready = !rst && (state_q == IDLE);
        rsp_valid = !rst && (state_q == RESP);
        DMRe      = !rst && ((state_q == READ) || (state_q == RMW_RD));
        DMWr      = !rst && (state_q == WRITE) && lat_we;
        addr      = '0;
        din       = '0;
        if (DMRe || DMWr)
            addr = {lat_addr[31:2], 2'b00};
        if (DMWr)
            din = lat_word ? lat_wdata : merge_q;
    end

endmodule
